// File: rtl/spike_event_scheduler_if.sv
// Timestamped spike event stream: source drives time/row/address with valid, scheduler returns ready.
interface spike_event_scheduler_if #(
  parameter int unsigned TIME_WIDTH = 16,
  parameter int unsigned ROW_WIDTH  = 1,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  ev_valid;
  logic                  ev_ready;
  logic [TIME_WIDTH-1:0] ev_time;
  logic [ROW_WIDTH-1:0]  ev_row;
  logic [ADDR_WIDTH-1:0] ev_addr;

  modport master (output ev_valid, output ev_time, output ev_row, output ev_addr, input ev_ready);
  modport slave  (input ev_valid, input ev_time, input ev_row, input ev_addr, output ev_ready);
endinterface

// File: rtl/spike_event_scheduler.sv
// Buffers timestamped spike events in an in-order FIFO and releases each one as a
// one-cycle per-row spike pulse once the internal timestamp (or delta countdown) reaches it.
module spike_event_scheduler #(
  parameter int unsigned NUM_SYNAPSE_ROWS = 2,
  parameter int unsigned ADDR_WIDTH       = 6,
  parameter int unsigned TIME_WIDTH       = 16,
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter int unsigned ROW_WIDTH        = ($clog2(NUM_SYNAPSE_ROWS) > 0) ? $clog2(NUM_SYNAPSE_ROWS) : 1
) (
  input  logic                                  main_clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  mode,
  input  logic                                  flush,
  input  logic                                  time_clear,
  spike_event_scheduler_if.slave                ev,
  output logic [NUM_SYNAPSE_ROWS-1:0]           spike_valid,
  output logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] spike_addr,
  output logic [TIME_WIDTH-1:0]                 now,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
  output logic [7:0]                            late_count,
  output logic [7:0]                            drop_count,
  output logic                                  busy
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  typedef struct packed {
    logic [TIME_WIDTH-1:0] t;
    logic [ROW_WIDTH-1:0]  row;
    logic [ADDR_WIDTH-1:0] addr;
  } event_t;

  event_t                mem [FIFO_DEPTH];
  event_t                head;
  event_t                wr_entry;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_nxt;
  logic [1:0]            state, state_nxt;
  logic                  mode_q;
  logic                  ready_q;
  logic [TIME_WIDTH-1:0] rel_elapsed;
  logic [TIME_WIDTH-1:0] abs_diff;
  logic [TIME_WIDTH-1:0] rel_target;
  logic                  accept, row_ok, push, drop, pop, due, run_active, empty;
  logic                  ready_nxt, busy_nxt;

  assign ev.ev_ready = ready_q;

  // Next-state logic; flush overrides every state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_RUN;
      ST_RUN:   if (!enable) state_nxt = ST_IDLE;
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_FLUSH;
  end

  // Handshake, release decision and FIFO bookkeeping
  always_comb begin
    accept     = ev.ev_valid && ready_q;
    row_ok     = 32'(ev.ev_row) < NUM_SYNAPSE_ROWS;
    push       = accept && !flush && row_ok;
    drop       = accept && !flush && !row_ok;
    empty      = (fifo_level == '0);
    head       = mem[rd_ptr];
    wr_entry   = '{t: ev.ev_time, row: ev.ev_row, addr: ev.ev_addr};
    abs_diff   = now - head.t;
    rel_target = (head.t == '0) ? TIME_WIDTH'(1) : head.t;
    // Absolute compare is wrap-aware: due when head time lies within the past half range
    due        = mode_q ? (rel_elapsed >= rel_target) : !abs_diff[TIME_WIDTH-1];
    run_active = (state == ST_RUN) && enable && !flush;
    pop        = run_active && !empty && due;
    count_nxt  = fifo_level;
    case ({push, pop})
      2'b10:   count_nxt = fifo_level + CNT_W'(1);
      2'b01:   count_nxt = fifo_level - CNT_W'(1);
      default: count_nxt = fifo_level;
    endcase
    if (flush) count_nxt = '0;
    ready_nxt = (count_nxt != CNT_W'(FIFO_DEPTH)) && (state_nxt != ST_FLUSH);
    busy_nxt  = (state_nxt != ST_IDLE) || (count_nxt != '0);
  end

  always_ff @(posedge main_clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      ready_q     <= 1'b0;
      busy        <= 1'b0;
      mode_q      <= 1'b0;
      rel_elapsed <= '0;
      now         <= '0;
      late_count  <= '0;
      drop_count  <= '0;
      spike_valid <= '0;
      spike_addr  <= '0;
    end else begin
      state      <= state_nxt;
      fifo_level <= count_nxt;
      ready_q    <= ready_nxt;
      busy       <= busy_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (state == ST_IDLE && enable) mode_q <= mode;
      // Delta reference restarts on RUN entry and on every release
      if (state == ST_IDLE)                         rel_elapsed <= '0;
      else if (pop)                                 rel_elapsed <= TIME_WIDTH'(1);
      else if (run_active && (rel_elapsed != '1))   rel_elapsed <= rel_elapsed + TIME_WIDTH'(1);
      if (time_clear)      now <= '0;
      else if (run_active) now <= now + TIME_WIDTH'(1);
      if (pop && !mode_q && (head.t != now) && (late_count != 8'hFF))
        late_count <= late_count + 8'd1;
      if (drop && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
      spike_valid <= '0;
      for (int unsigned r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
        if (pop && (32'(head.row) == r)) begin
          spike_valid[r]                          <= 1'b1;
          spike_addr[r*ADDR_WIDTH +: ADDR_WIDTH] <= head.addr;
        end
      end
    end
  end
endmodule

// File: tb/tb_spike_event_scheduler.sv
// Directed bench for spike_event_scheduler; an 8-bit timestamp keeps the wrap case short.
module tb_spike_event_scheduler;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 6;
  localparam int unsigned TW = 8;
  localparam int unsigned FD = 16;
  localparam int unsigned RW = 2;

  logic              main_clk;
  logic              reset;
  logic              enable, mode, flush, time_clear;
  logic [NR-1:0]     spike_valid;
  logic [NR*AW-1:0]  spike_addr;
  logic [TW-1:0]     now;
  logic [4:0]        fifo_level;
  logic [7:0]        late_count, drop_count;
  logic              busy;
  int                errors = 0;
  int                checks = 0;

  spike_event_scheduler_if #(.TIME_WIDTH(TW), .ROW_WIDTH(RW), .ADDR_WIDTH(AW)) ev_if ();

  spike_event_scheduler #(
    .NUM_SYNAPSE_ROWS(NR), .ADDR_WIDTH(AW), .TIME_WIDTH(TW), .FIFO_DEPTH(FD), .ROW_WIDTH(RW)
  ) dut (
    .main_clk(main_clk), .reset(reset), .enable(enable), .mode(mode), .flush(flush),
    .time_clear(time_clear), .ev(ev_if), .spike_valid(spike_valid), .spike_addr(spike_addr),
    .now(now), .fifo_level(fifo_level), .late_count(late_count), .drop_count(drop_count),
    .busy(busy)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  task automatic step(input int n);
    repeat (n) @(posedge main_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push_ev(input int t, input int row, input int addr);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_time  = TW'(t);
    ev_if.ev_row   = RW'(row);
    ev_if.ev_addr  = AW'(addr);
    step(1);
    ev_if.ev_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 1'b0; flush = 1'b0; time_clear = 1'b0;
    ev_if.ev_valid = 1'b0; ev_if.ev_time = '0; ev_if.ev_row = '0; ev_if.ev_addr = '0;
    step(2);
    chk("rst_ready", 32'(ev_if.ev_ready), 0);
    chk("rst_now", 32'(now), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_spike", 32'(spike_valid), 0);
    reset = 1'b1;
    step(1);
    chk("ready_after_rst", 32'(ev_if.ev_ready), 1);

    // Absolute mode, three events loaded in IDLE
    push_ev(50, 1, 10);
    push_ev(55, 1, 21);
    push_ev(100, 0, 10);
    chk("abs_level", 32'(fifo_level), 3);
    chk("abs_busy", 32'(busy), 1);
    enable = 1'b1;
    step(1);
    chk("abs_now_entry", 32'(now), 0);
    step(50);
    chk("abs_now50_quiet", 32'(spike_valid), 0);
    step(1);
    chk("abs_now51", 32'(now), 51);
    chk("abs_spike51", 32'(spike_valid), 2);
    chk("abs_addr51", 32'(spike_addr[11:6]), 10);
    step(1);
    chk("abs_pulse_width", 32'(spike_valid), 0);
    step(4);
    chk("abs_spike56", 32'(spike_valid), 2);
    chk("abs_addr56", 32'(spike_addr[11:6]), 21);
    step(45);
    chk("abs_now101", 32'(now), 101);
    chk("abs_spike101", 32'(spike_valid), 1);
    chk("abs_addr101", 32'(spike_addr), (21 << 6) | 10);
    chk("abs_late0", 32'(late_count), 0);
    chk("abs_empty", 32'(fifo_level), 0);

    // Burst of late events: now=20 at RUN entry, times 10,10,10
    enable = 1'b0;
    step(1);
    chk("idle_hold_now", 32'(now), 101);
    time_clear = 1'b1;
    step(1);
    time_clear = 1'b0;
    chk("time_clear", 32'(now), 0);
    enable = 1'b1;
    step(21);
    enable = 1'b0;
    step(1);
    chk("burst_now20", 32'(now), 20);
    push_ev(10, 0, 1);
    push_ev(10, 0, 2);
    push_ev(10, 0, 3);
    enable = 1'b1;
    step(1);
    chk("burst_entry_quiet", 32'(spike_valid), 0);
    step(1);
    chk("burst1", 32'(spike_valid), 1);
    chk("burst1_addr", 32'(spike_addr[5:0]), 1);
    step(1);
    chk("burst2", 32'(spike_valid), 1);
    chk("burst2_addr", 32'(spike_addr[5:0]), 2);
    step(1);
    chk("burst3", 32'(spike_valid), 1);
    chk("burst3_addr", 32'(spike_addr[5:0]), 3);
    chk("burst_late", 32'(late_count), 3);
    step(1);
    chk("burst_end", 32'(spike_valid), 0);
    chk("burst_now24", 32'(now), 24);

    // Fill the FIFO with ev_valid held; only the first entry is due at now=24
    enable = 1'b0;
    step(1);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_row   = '0;
    for (int i = 0; i < 16; i++) begin
      ev_if.ev_time = (i == 0) ? TW'(24) : TW'(124);
      ev_if.ev_addr = AW'(i);
      step(1);
    end
    chk("fill_ready_low", 32'(ev_if.ev_ready), 0);
    step(1);
    ev_if.ev_valid = 1'b0;
    chk("fill_level16", 32'(fifo_level), 16);
    enable = 1'b1;
    step(1);
    chk("fill_ready_still_low", 32'(ev_if.ev_ready), 0);
    step(1);
    chk("fill_pop_level", 32'(fifo_level), 15);
    chk("fill_pop_ready", 32'(ev_if.ev_ready), 1);
    chk("fill_pop_spike", 32'(spike_valid), 1);
    chk("fill_pop_ontime", 32'(late_count), 3);

    // Flush with a simultaneous push: nothing survives, IDLE two cycles later
    enable = 1'b0;
    flush = 1'b1;
    ev_if.ev_valid = 1'b1;
    ev_if.ev_time = TW'(30);
    step(1);
    flush = 1'b0;
    ev_if.ev_valid = 1'b0;
    chk("flush_level", 32'(fifo_level), 0);
    chk("flush_ready", 32'(ev_if.ev_ready), 0);
    chk("flush_busy", 32'(busy), 1);
    chk("flush_spike", 32'(spike_valid), 0);
    step(1);
    chk("flush_idle_busy", 32'(busy), 0);
    chk("flush_idle_ready", 32'(ev_if.ev_ready), 1);
    chk("flush_idle_level", 32'(fifo_level), 0);

    // Out-of-range row is accepted but dropped
    push_ev(0, 3, 1);
    chk("drop_count", 32'(drop_count), 1);
    chk("drop_level", 32'(fifo_level), 0);

    // Relative mode: deltas 5,0,3 due at 5,6,9 after RUN entry
    mode = 1'b1;
    time_clear = 1'b1;
    step(1);
    time_clear = 1'b0;
    push_ev(5, 0, 5);
    push_ev(0, 1, 6);
    push_ev(3, 0, 7);
    enable = 1'b1;
    step(1);
    chk("rel_now_entry", 32'(now), 0);
    step(5);
    chk("rel_quiet5", 32'(spike_valid), 0);
    step(1);
    chk("rel_spike_a", 32'(spike_valid), 1);
    chk("rel_addr_a", 32'(spike_addr[5:0]), 5);
    step(1);
    chk("rel_spike_b", 32'(spike_valid), 2);
    chk("rel_addr_b", 32'(spike_addr), (6 << 6) | 5);
    step(2);
    chk("rel_quiet9", 32'(spike_valid), 0);
    step(1);
    chk("rel_now10", 32'(now), 10);
    chk("rel_spike_c", 32'(spike_valid), 1);
    chk("rel_addr_c", 32'(spike_addr[5:0]), 7);
    chk("rel_no_late", 32'(late_count), 3);

    // Wrap: now=250, absolute time 4 is in the future and releases after wrap
    enable = 1'b0;
    mode = 1'b0;
    time_clear = 1'b1;
    step(1);
    time_clear = 1'b0;
    enable = 1'b1;
    step(251);
    enable = 1'b0;
    step(1);
    chk("wrap_now250", 32'(now), 250);
    push_ev(4, 1, 9);
    enable = 1'b1;
    step(1);
    step(1);
    chk("wrap_not_immediate", 32'(spike_valid), 0);
    step(9);
    chk("wrap_now4", 32'(now), 4);
    chk("wrap_quiet4", 32'(spike_valid), 0);
    step(1);
    chk("wrap_spike", 32'(spike_valid), 2);
    chk("wrap_addr", 32'(spike_addr[11:6]), 9);
    chk("wrap_ontime", 32'(late_count), 3);

    // Asynchronous reset mid-pulse
    #2;
    reset = 1'b0;
    #1;
    chk("arst_spike", 32'(spike_valid), 0);
    chk("arst_late", 32'(late_count), 0);
    chk("arst_drop", 32'(drop_count), 0);
    chk("arst_now", 32'(now), 0);
    chk("arst_ready", 32'(ev_if.ev_ready), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
